fir_filter: RTL and testbench

16-tap fixed-coefficient, low-pass, direct-form FIR filter for 16-bit two's-complement sample streams. It accepts one sample every clock and produces one filtered sample every clock. It sits between a sample source (for example a waveform ROM or ADC interface) and downstream consumers. The coefficients form a symmetric triangular window with exactly unity DC gain.

---
 rtl/fir_pkg.sv | 40 ++++
 rtl/fir_round_sat.sv | 11 +
 rtl/fir_filter.sv | 61 ++++++
 tb/tb_fir_filter.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants, coefficient set and round/saturate helper for the 16-tap
// triangular-window low-pass FIR.
package fir_pkg;

   localparam int N     = 16;
   localparam int TAPS  = 16;
   localparam int ACC_W = 32;
   localparam int SH    = 15;
   localparam int RW    = ACC_W + 1 - SH;

   // Q0.15 triangular window; the sixteen weights add up to exactly 32768.
   localparam logic signed [N-1:0] h [0:TAPS-1] = '{
      16'sd256,  16'sd768,  16'sd1280, 16'sd1792,
      16'sd2304, 16'sd2816, 16'sd3328, 16'sd3840,
      16'sd3840, 16'sd3328, 16'sd2816, 16'sd2304,
      16'sd1792, 16'sd1280, 16'sd768,  16'sd256
   };

   localparam logic signed [ACC_W:0] RND    = (ACC_W+1)'(2**(SH-1));
   localparam logic signed [RW-1:0]  SAT_HI = RW'(2**(N-1) - 1);
   localparam logic signed [RW-1:0]  SAT_LO = RW'(-(2**(N-1)));

   // Round half up, arithmetic shift, then clamp to the N-bit signed range.
   function automatic logic signed [N-1:0] round_sat(input logic signed [ACC_W-1:0] acc);
      logic signed [ACC_W:0] sum;
      logic signed [RW-1:0]  shifted;
      logic signed [N-1:0]   res;
      sum     = (ACC_W+1)'(acc) + RND;
      shifted = sum[ACC_W:SH];
      if (shifted > SAT_HI) begin
         res = SAT_HI[N-1:0];
      end else if (shifted < SAT_LO) begin
         res = SAT_LO[N-1:0];
      end else begin
         res = shifted[N-1:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational ACC_W -> N bit round-half-up and saturate stage.
module fir_round_sat
   import fir_pkg::*;
(
   input  logic [ACC_W-1:0] acc_in,
   output logic [N-1:0]     data_o
);

   assign data_o = round_sat($signed(acc_in));

endmodule

// File: rtl/fir_filter.sv
// 16-tap fixed-coefficient direct-form FIR, one sample in and out per clock.
// Symmetric pairs are pre-added so only eight products are formed.
module fir_filter
   import fir_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] data_in,
   output logic [N-1:0] data_out
);

   logic signed [N-1:0]     tap_q [TAPS];
   logic signed [N-1:0]     tap_d [TAPS];
   logic signed [N:0]       pre;
   logic signed [ACC_W-1:0] acc;
   logic        [N-1:0]     rounded;
   logic        [N-1:0]     data_out_q;
   logic        [N-1:0]     data_out_d;

   always_comb begin
      tap_d[0] = data_in;
      for (int k = 1; k < TAPS; k++) begin
         tap_d[k] = tap_q[k-1];
      end
   end

   // Products use the taps held before the edge, so a new sample reaches the
   // output one edge after it is captured.
   always_comb begin
      pre = '0;
      acc = '0;
      for (int k = 0; k < TAPS/2; k++) begin
         pre = (N+1)'(tap_q[k]) + (N+1)'(tap_q[TAPS-1-k]);
         acc = acc + ACC_W'(pre) * ACC_W'(h[k]);
      end
   end

   fir_round_sat u_round_sat (
      .acc_in (acc),
      .data_o (rounded)
   );

   assign data_out_d = rounded;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < TAPS; k++) begin
            tap_q[k] <= '0;
         end
         data_out_q <= '0;
      end else begin
         for (int k = 0; k < TAPS; k++) begin
            tap_q[k] <= tap_d[k];
         end
         data_out_q <= data_out_d;
      end
   end

   assign data_out = data_out_q;

endmodule

// File: tb/tb_fir_filter.sv
// Directed bench for fir_filter: reset, impulse, step, extremes, Nyquist,
// mid-stream reset and a sine loop against an independent direct-form model.
module tb_fir_filter;

   logic               clk;
   logic               reset;
   logic signed [15:0] data_in;
   logic signed [15:0] data_out;

   int checks = 0;
   int errors = 0;
   int hist [16];
   int sine_tbl [32];

   fir_filter dut (
      .clk      (clk),
      .reset    (reset),
      .data_in  (data_in),
      .data_out (data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int coef(input int k);
      return (k < 8) ? 256 * (2*k + 1) : 256 * (2*(15-k) + 1);
   endfunction

   function automatic int model_out();
      longint acc = 0;
      longint r;
      for (int k = 0; k < 16; k++) acc += longint'(coef(k)) * longint'(hist[k]);
      r = (acc + 16384) >>> 15;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      return int'(r);
   endfunction

   task automatic clear_model();
      for (int k = 0; k < 16; k++) hist[k] = 0;
   endtask

   task automatic check(input string tag, input int exp);
      logic signed [15:0] e;
      e = 16'(exp);
      checks++;
      assert (data_out === e) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, data_out, e);
      end
   endtask

   // Apply one sample across one rising edge and compare with the model.
   task automatic drive(input int v, input string tag);
      int exp;
      exp = model_out();
      for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = v;
      data_in = 16'(v);
      @(posedge clk);
      #1;
      check(tag, exp);
   endtask

   initial begin
      int imp_tbl [16] = '{128, 384, 640, 896, 1152, 1408, 1664, 1920,
                           1920, 1664, 1408, 1152, 896, 640, 384, 128};

      for (int i = 0; i < 32; i++)
         sine_tbl[i] = $rtoi(20000.0 * $sin(2.0 * 3.14159265358979 * i / 32.0));

      // Reset held low with random input
      reset   = 1'b0;
      data_in = 16'($urandom);
      clear_model();
      for (int i = 0; i < 5; i++) begin
         data_in = 16'($urandom);
         @(posedge clk);
         #1;
         check("reset_hold", 0);
      end
      reset = 1'b1;

      // Impulse
      drive(16384, "imp_capture");
      check("imp_capture_hand", 0);
      for (int i = 0; i < 16; i++) begin
         drive(0, "imp_model");
         check("imp_hand", imp_tbl[i]);
      end
      drive(0, "imp_gone");
      check("imp_gone_hand", 0);

      // Step to 1000
      drive(1000, "step_e1");
      check("step_e1_hand", 0);
      drive(1000, "step_e2");
      check("step_e2_hand", 8);
      drive(1000, "step_e3");
      check("step_e3_hand", 31);
      drive(1000, "step_e4");
      check("step_e4_hand", 70);
      for (int i = 0; i < 16; i++) drive(1000, "step_ramp");
      check("step_settled", 1000);

      // Positive and negative full-scale DC
      for (int i = 0; i < 20; i++) drive(32767, "dc_max");
      check("dc_max_hand", 32767);
      for (int i = 0; i < 20; i++) drive(-32768, "dc_min");
      check("dc_min_hand", -32768);

      // Nyquist: alternating +/-20000
      for (int i = 0; i < 17; i++) drive((i % 2 == 0) ? 20000 : -20000, "nyq_fill");
      for (int i = 17; i < 21; i++) begin
         drive((i % 2 == 0) ? 20000 : -20000, "nyq_model");
         check("nyq_zero", 0);
      end

      // Mid-stream asynchronous reset
      for (int i = 0; i < 20; i++) drive(1000, "mid_settle");
      check("mid_settled", 1000);
      #2;
      reset = 1'b0;
      #1;
      check("async_reset_now", 0);
      clear_model();
      @(posedge clk);
      #1;
      check("async_reset_held", 0);
      reset = 1'b1;
      drive(1000, "restart_e1");
      check("restart_e1_hand", 0);
      drive(1000, "restart_e2");
      check("restart_e2_hand", 8);
      drive(1000, "restart_e3");
      check("restart_e3_hand", 31);
      drive(1000, "restart_e4");
      check("restart_e4_hand", 70);
      for (int i = 0; i < 16; i++) drive(1000, "restart_ramp");
      check("restart_settled", 1000);

      // Periodic sine against the model
      for (int i = 0; i < 128; i++) drive(sine_tbl[i % 32], "sine");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
